// File: rtl/bw_io_sstl_bscan_array.sv
// Boundary-scan cell array for a group of SSTL pad channels.
// Each channel carries an input cell, an optional ODT cell, an output cell
// and an output-enable cell. Cells are chained with channel 0 nearest bsi.
// The design has a capture/shift register (sr) and an update register (ur).
// In test mode the pads are driven from ur. In functional mode they pass
// the core and receiver signals straight through.
module bw_io_sstl_bscan_array #(
  parameter  int NCH        = 8,
  parameter  int ODT_EN     = 1,
  parameter  int STRICT_UPD = 1,
  localparam int K          = 3 + ODT_EN,
  localparam int L          = NCH * K,
  localparam int CW         = $clog2(L + 2)
) (
  input  logic            clk,
  input  logic            rst_l,
  input  logic            capture_dr,
  input  logic            shift_dr,
  input  logic            update_dr,
  input  logic            bsi,
  output logic            bso,
  input  logic            mode_ctrl,
  input  logic            hiz_l,
  input  logic            odt_enable_mask,
  input  logic [NCH-1:0]  rcv_in,
  input  logic [NCH-1:0]  data_in,
  input  logic [NCH-1:0]  drv_oe,
  output logic [NCH-1:0]  to_core,
  output logic [NCH-1:0]  data_out,
  output logic [NCH-1:0]  oe,
  output logic [NCH-1:0]  odt_enable,
  output logic [CW-1:0]   shift_cnt,
  output logic            len_ok
);

  localparam logic [CW-1:0] L_CNT   = CW'(L);
  localparam logic [CW-1:0] SAT_CNT = CW'(L + 1);
  localparam logic [CW-1:0] ONE_CNT = CW'(1);

  logic [L-1:0]   sr_q,  sr_d;
  logic [L-1:0]   ur_q,  ur_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           len_ok_q, len_ok_d;
  logic [NCH-1:0] odt_in_s;

  // ODT is requested only when the driver is off and the global mask is clear.
  assign odt_in_s = ~(drv_oe | {NCH{odt_enable_mask}});

  // Next-state logic for the chain, the update register and the shift counter.
  // Update samples the pre-edge sr and count, so it combines cleanly with a
  // capture or a shift in the same cycle. Capture takes priority over shift.
  always_comb begin
    sr_d     = sr_q;
    ur_d     = ur_q;
    cnt_d    = cnt_q;
    len_ok_d = len_ok_q;

    if (capture_dr) begin
      for (int c = 0; c < NCH; c++) begin
        sr_d[c*K] = rcv_in[c];
        if (ODT_EN != 0) begin
          sr_d[c*K+1] = odt_in_s[c];
        end else begin
          // Without an ODT cell, b+1 is the output cell.
          sr_d[c*K+1] = data_in[c];
        end
        sr_d[c*K+1+ODT_EN] = data_in[c];
        sr_d[c*K+K-1]      = drv_oe[c];
      end
      cnt_d = '0;
    end else if (shift_dr) begin
      sr_d = {sr_q[L-2:0], bsi};
      if (cnt_q != SAT_CNT) begin
        cnt_d = cnt_q + ONE_CNT;
      end else begin
        cnt_d = cnt_q;
      end
    end else begin
      sr_d  = sr_q;
      cnt_d = cnt_q;
    end

    if (update_dr) begin
      len_ok_d = (cnt_q == L_CNT);
      if ((STRICT_UPD == 0) || (cnt_q == L_CNT)) begin
        ur_d = sr_q;
      end else begin
        ur_d = ur_q;
      end
    end else begin
      len_ok_d = len_ok_q;
      ur_d     = ur_q;
    end
  end

  // State registers; reset clears everything at once, without waiting for clk.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      sr_q     <= '0;
      ur_q     <= '0;
      cnt_q    <= '0;
      len_ok_q <= 1'b0;
    end else begin
      sr_q     <= sr_d;
      ur_q     <= ur_d;
      cnt_q    <= cnt_d;
      len_ok_q <= len_ok_d;
    end
  end

  assign bso       = sr_q[L-1];
  assign shift_cnt = cnt_q;
  assign len_ok    = len_ok_q;

  // Pad-side muxing. Test mode drives the pads from ur, with hiz_l gating the
  // drivers and ODT. Functional mode passes the signals through. ur clears
  // asynchronously, so test-mode outputs go to 0 during reset.
  always_comb begin
    to_core    = rcv_in;
    data_out   = data_in;
    oe         = drv_oe;
    odt_enable = odt_in_s;
    if (mode_ctrl) begin
      for (int c = 0; c < NCH; c++) begin
        to_core[c]  = ur_q[c*K];
        data_out[c] = ur_q[c*K+1+ODT_EN];
        oe[c]       = ur_q[c*K+K-1] & hiz_l;
        if (ODT_EN != 0) begin
          odt_enable[c] = ur_q[c*K+1] & hiz_l;
        end else begin
          odt_enable[c] = 1'b0;
        end
      end
    end else begin
      to_core    = rcv_in;
      data_out   = data_in;
      oe         = drv_oe;
      odt_enable = odt_in_s;
    end
  end

endmodule

// File: tb/tb_bw_io_sstl_bscan_array.sv
// Scoreboard bench for bw_io_sstl_bscan_array (NCH=2, ODT_EN=1, L=8).
module tb_bw_io_sstl_bscan_array;

  localparam int CW = 4;

  logic clk = 1'b0;
  logic rst_l;
  logic capture_dr, shift_dr, update_dr, bsi;
  logic bso;
  logic mode_ctrl, hiz_l, odt_enable_mask;
  logic [1:0] rcv_in, data_in, drv_oe;
  logic [1:0] to_core, data_out, oe, odt_enable;
  logic [CW-1:0] shift_cnt;
  logic len_ok;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    int          sel;
    logic [63:0] exp;
    string       name;
  } exp_t;

  exp_t sb_q[$];
  event sample_ev;

  bw_io_sstl_bscan_array #(.NCH(2), .ODT_EN(1), .STRICT_UPD(1)) dut (
    .clk(clk), .rst_l(rst_l),
    .capture_dr(capture_dr), .shift_dr(shift_dr), .update_dr(update_dr),
    .bsi(bsi), .bso(bso),
    .mode_ctrl(mode_ctrl), .hiz_l(hiz_l), .odt_enable_mask(odt_enable_mask),
    .rcv_in(rcv_in), .data_in(data_in), .drv_oe(drv_oe),
    .to_core(to_core), .data_out(data_out), .oe(oe), .odt_enable(odt_enable),
    .shift_cnt(shift_cnt), .len_ok(len_ok)
  );

  always #5 clk = ~clk;

  localparam int S_BSO = 0, S_CNT = 1, S_LOK = 2, S_TOC = 3, S_DOUT = 4,
                 S_OE = 5, S_ODT = 6, S_SR = 7, S_UR = 8;

  function automatic logic [63:0] actual(input int sel);
    case (sel)
      S_BSO:   actual = {63'd0, bso};
      S_CNT:   actual = {60'd0, shift_cnt};
      S_LOK:   actual = {63'd0, len_ok};
      S_TOC:   actual = {62'd0, to_core};
      S_DOUT:  actual = {62'd0, data_out};
      S_OE:    actual = {62'd0, oe};
      S_ODT:   actual = {62'd0, odt_enable};
      S_SR:    actual = {56'd0, dut.sr_q};
      S_UR:    actual = {56'd0, dut.ur_q};
      default: actual = 64'hDEAD;
    endcase
  endfunction

  // Monitor: whenever a sample is presented, drain and compare the queue.
  initial begin
    exp_t e;
    logic [63:0] a;
    forever begin
      @(sample_ev);
      while (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        a = actual(e.sel);
        n_tests++;
        if (a !== e.exp) begin
          n_fail++;
          $display("FAIL %s: got %0h expected %0h", e.name, a, e.exp);
        end
      end
    end
  end

  task automatic expect_v(input int sel, input logic [63:0] exp, input string name);
    exp_t e;
    e.sel = sel; e.exp = exp; e.name = name;
    sb_q.push_back(e);
  endtask

  task automatic flush();
    -> sample_ev;
    #1;
  endtask

  task automatic cyc(input logic cap, input logic sh, input logic upd, input logic b);
    capture_dr = cap; shift_dr = sh; update_dr = upd; bsi = b;
    @(posedge clk);
    #1;
    capture_dr = 1'b0; shift_dr = 1'b0; update_dr = 1'b0;
  endtask

  task automatic pads(input logic [1:0] t, input logic [1:0] d, input logic [1:0] o,
                      input logic [1:0] z, input string tag);
    expect_v(S_TOC,  {62'd0, t}, {tag, "_to_core"});
    expect_v(S_DOUT, {62'd0, d}, {tag, "_data_out"});
    expect_v(S_OE,   {62'd0, o}, {tag, "_oe"});
    expect_v(S_ODT,  {62'd0, z}, {tag, "_odt"});
  endtask

  initial begin
    logic [7:0] bso_exp;
    logic [7:0] pat;
    rst_l = 1'b0;
    capture_dr = 1'b0; shift_dr = 1'b0; update_dr = 1'b0; bsi = 1'b0;
    mode_ctrl = 1'b0; hiz_l = 1'b1; odt_enable_mask = 1'b0;
    rcv_in = 2'b10; data_in = 2'b01; drv_oe = 2'b01;
    #2;
    // Passthrough during reset, mode 0
    pads(2'b10, 2'b01, 2'b01, 2'b10, "rst_pass");
    flush();
    odt_enable_mask = 1'b1; #1;
    expect_v(S_ODT, 64'd0, "rst_pass_mask");
    flush();
    // Mode 1 during reset: everything 0
    mode_ctrl = 1'b1; odt_enable_mask = 1'b0; #1;
    pads(2'b00, 2'b00, 2'b00, 2'b00, "rst_m1");
    expect_v(S_BSO, 64'd0, "rst_bso");
    expect_v(S_CNT, 64'd0, "rst_cnt");
    expect_v(S_LOK, 64'd0, "rst_lok");
    flush();
    @(negedge clk);
    rst_l = 1'b1;

    // Capture then 8 shifts: bso sequence 1,0,0,1,1,1,0,0
    drv_oe = 2'b11;
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    expect_v(S_SR, 64'h9C, "cap_sr");
    expect_v(S_CNT, 64'd0, "cap_cnt");
    flush();
    bso_exp = 8'b1001_1100;
    for (int i = 7; i >= 0; i--) begin
      expect_v(S_BSO, {63'd0, bso_exp[i]}, $sformatf("cap_bso%0d", 7 - i));
      flush();
      cyc(1'b0, 1'b1, 1'b0, 1'b0);
    end
    expect_v(S_CNT, 64'd8, "cap_cnt8");
    flush();

    // Shift A5 LSB first, update, test mode outputs
    pat = 8'hA5;
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) cyc(1'b0, 1'b1, 1'b0, pat[i]);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    mode_ctrl = 1'b1; hiz_l = 1'b1; #1;
    expect_v(S_UR, 64'hA5, "upd_ur");
    expect_v(S_LOK, 64'd1, "upd_lok");
    pads(2'b01, 2'b01, 2'b10, 2'b10, "upd_m1");
    flush();

    // Strict update: 7 shifts, update suppressed; idle cycles hold state
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) cyc(1'b0, 1'b1, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    expect_v(S_UR, 64'hA5, "strict_ur");
    expect_v(S_LOK, 64'd0, "strict_lok");
    expect_v(S_CNT, 64'd7, "strict_cnt");
    expect_v(S_SR, 64'h7F, "hold_sr");
    flush();

    // hiz_l gating with ur all ones
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) cyc(1'b0, 1'b1, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    hiz_l = 1'b0; #1;
    expect_v(S_UR, 64'hFF, "hiz_ur");
    pads(2'b11, 2'b11, 2'b00, 2'b00, "hiz0");
    flush();
    hiz_l = 1'b1; #1;
    pads(2'b11, 2'b11, 2'b11, 2'b11, "hiz1");
    flush();

    // Capture/shift collision from sr=FF
    drv_oe = 2'b01;
    cyc(1'b1, 1'b1, 1'b0, 1'b1);
    expect_v(S_SR, 64'h3C, "coll_sr");
    expect_v(S_CNT, 64'd0, "coll_cnt");
    expect_v(S_BSO, 64'd0, "coll_bso");
    flush();

    // Update with shift: pre-shift sr/count; then count saturation
    pat = 8'b0000_0011;
    for (int i = 0; i < 8; i++) cyc(1'b0, 1'b1, 1'b0, pat[i]);
    cyc(1'b0, 1'b1, 1'b1, 1'b1);
    expect_v(S_UR, 64'hC0, "updsh_ur");
    expect_v(S_LOK, 64'd1, "updsh_lok");
    expect_v(S_SR, 64'h81, "updsh_sr");
    expect_v(S_CNT, 64'd9, "updsh_cnt");
    flush();
    cyc(1'b0, 1'b1, 1'b0, 1'b1);
    expect_v(S_CNT, 64'd9, "sat_cnt");
    expect_v(S_SR, 64'h03, "sat_sr");
    flush();

    // Update with capture: count 9 rejected, then count 8 accepted
    cyc(1'b1, 1'b0, 1'b1, 1'b0);
    expect_v(S_UR, 64'hC0, "updcap_bad_ur");
    expect_v(S_LOK, 64'd0, "updcap_bad_lok");
    expect_v(S_SR, 64'h3C, "updcap_bad_sr");
    flush();
    for (int i = 0; i < 8; i++) cyc(1'b0, 1'b1, 1'b0, 1'b1);
    cyc(1'b1, 1'b0, 1'b1, 1'b0);
    expect_v(S_UR, 64'hFF, "updcap_ur");
    expect_v(S_LOK, 64'd1, "updcap_lok");
    expect_v(S_SR, 64'h3C, "updcap_sr");
    expect_v(S_CNT, 64'd0, "updcap_cnt");
    flush();

    // Reset mid-sequence between clock edges
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 1'b0, 1'b1);
    expect_v(S_SR, 64'hCF, "pre_rst_sr");
    expect_v(S_CNT, 64'd4, "pre_rst_cnt");
    flush();
    rst_l = 1'b0; #1;
    expect_v(S_SR, 64'd0, "arst_sr");
    expect_v(S_UR, 64'd0, "arst_ur");
    expect_v(S_BSO, 64'd0, "arst_bso");
    expect_v(S_LOK, 64'd0, "arst_lok");
    expect_v(S_CNT, 64'd0, "arst_cnt");
    pads(2'b00, 2'b00, 2'b00, 2'b00, "arst_m1");
    flush();
    rst_l = 1'b1;
    for (int i = 0; i < 8; i++) cyc(1'b0, 1'b1, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    expect_v(S_LOK, 64'd1, "post_rst_lok");
    expect_v(S_UR, 64'hFF, "post_rst_ur");
    flush();

    // Functional passthrough after reset
    mode_ctrl = 1'b0; rcv_in = 2'b01; data_in = 2'b10; drv_oe = 2'b00;
    odt_enable_mask = 1'b0; #1;
    pads(2'b01, 2'b10, 2'b00, 2'b11, "pass");
    flush();

    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d expected 0", sb_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
